video_stream_sink: RTL and testbench

- Receiving end of the Avalon-ST pixel stream that pixel_iterator produces.
- Accepts 16-bit RGB565 pixel beats framed by start/end-of-packet and tracks raster position.
- Writes each pixel to a word-addressed frame-buffer master port with waitrequest backpressure.
- Reports completed frames and framing errors. Used to capture solver output for HPS readback and as a bench-side checker for the stream source.

---
 rtl/video_stream_sink.sv | 117 +++++++++++
 tb/tb_video_stream_sink.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_sink.sv
// Avalon-ST RGB565 pixel sink: frames the stream by SOP/EOP and writes each
// pixel to a word-addressed frame buffer, counting frames and framing errors.
module video_stream_sink #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 19
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sink_data,
    input  logic              sink_valid,
    input  logic              sink_startofpacket,
    input  logic              sink_endofpacket,
    output logic              sink_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_write,
    input  logic              mem_waitrequest,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic [7:0]        err_count,
    output logic              busy
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr, addr_d, cur;
    logic              last_pending, last_d;
    logic              accept, wr_done, load, err_inc;
    logic              orphan, restart, is_last, good_end, bad_end;

    assign sink_ready = !mem_write || !mem_waitrequest;
    assign accept     = sink_valid && sink_ready;
    assign wr_done    = mem_write && !mem_waitrequest;
    assign frame_done = wr_done && last_pending;
    assign busy       = (state == RECV) || mem_write;

    // SOP always rewinds to pixel 0, whichever state it arrives in
    assign cur      = sink_startofpacket ? '0 : addr;
    assign is_last  = (cur == LAST);
    assign orphan   = (state == IDLE) && !sink_startofpacket;
    assign restart  = (state == RECV) && sink_startofpacket;
    assign good_end = !orphan && !restart && sink_endofpacket && is_last;
    assign bad_end  = !orphan && !restart
                      && (sink_endofpacket != is_last);

    always_comb begin
        state_d = state;
        addr_d  = addr;
        load    = 1'b0;
        last_d  = 1'b0;
        err_inc = 1'b0;
        if (accept) begin
            unique case (1'b1)
                orphan: begin
                    err_inc = 1'b1;
                end
                restart: begin
                    load    = 1'b1;
                    err_inc = 1'b1;
                    state_d = RECV;
                    addr_d  = ADDR_W'(1);
                end
                good_end: begin
                    load    = 1'b1;
                    last_d  = 1'b1;
                    state_d = IDLE;
                end
                bad_end: begin
                    load    = 1'b1;
                    err_inc = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    load    = 1'b1;
                    state_d = RECV;
                    addr_d  = cur + ADDR_W'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            addr          <= '0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            last_pending  <= 1'b0;
            frame_count   <= '0;
            err_count     <= '0;
        end else begin
            state <= state_d;
            addr  <= addr_d;
            if (load) begin
                mem_write     <= 1'b1;
                mem_address   <= cur;
                mem_writedata <= sink_data;
                last_pending  <= last_d;
            end else if (wr_done) begin
                mem_write    <= 1'b0;
                last_pending <= 1'b0;
            end
            if (frame_done)
                frame_count <= frame_count + 16'd1;
            if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_video_stream_sink.sv
// Bench for video_stream_sink: directed framing cases plus randomized frames,
// checked every cycle against a frame-position reference model.
module tb_video_stream_sink;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int DW   = 16;
    localparam int AW   = 3;
    localparam int NPIX = W * H;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] sink_data = '0;
    logic          sink_valid = 1'b0;
    logic          sink_startofpacket = 1'b0;
    logic          sink_endofpacket = 1'b0;
    logic          sink_ready;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_writedata;
    logic          mem_write;
    logic          mem_waitrequest = 1'b0;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic [7:0]    err_count;
    logic          busy;

    video_stream_sink #(
        .WIDTH(W), .HEIGHT(H), .DATA_W(DW), .ADDR_W(AW)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .sink_data(sink_data),
        .sink_valid(sink_valid),
        .sink_startofpacket(sink_startofpacket),
        .sink_endofpacket(sink_endofpacket),
        .sink_ready(sink_ready),
        .mem_address(mem_address),
        .mem_writedata(mem_writedata),
        .mem_write(mem_write),
        .mem_waitrequest(mem_waitrequest),
        .frame_done(frame_done),
        .frame_count(frame_count),
        .err_count(err_count),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: frame position plus one pending write slot
    bit          m_wr, m_last, m_in, m_acc, m_restart;
    int          m_pos, m_idx;
    int          m_addr, m_data;
    logic [15:0] m_fc;
    int          m_ec;

    always @(posedge clock) begin
        if (!reset_n) begin
            m_wr = 0; m_last = 0; m_in = 0; m_pos = 0;
            m_addr = 0; m_data = 0; m_fc = 0; m_ec = 0;
        end else begin
            m_acc = sink_valid && (!m_wr || !mem_waitrequest);
            if (m_wr && !mem_waitrequest) begin
                if (m_last) m_fc = m_fc + 16'd1;
                m_wr = 0;
                m_last = 0;
            end
            if (m_acc) begin
                if (!m_in && !sink_startofpacket) begin
                    if (m_ec < 255) m_ec++;
                end else begin
                    m_restart = m_in && sink_startofpacket;
                    m_idx = sink_startofpacket ? 0 : m_pos;
                    if (m_restart && m_ec < 255) m_ec++;
                    m_wr = 1;
                    m_addr = m_idx;
                    m_data = int'(sink_data);
                    m_last = 0;
                    if (!m_restart &&
                        (sink_endofpacket || m_idx == NPIX - 1)) begin
                        m_in = 0;
                        if (sink_endofpacket && m_idx == NPIX - 1)
                            m_last = 1;
                        else if (m_ec < 255)
                            m_ec++;
                    end else begin
                        m_in = 1;
                        m_pos = m_idx + 1;
                    end
                end
            end
        end
    end

    bit run_cmp = 0;
    int n_wr, n_done, n_nrdy;

    always @(negedge clock) begin
        if (run_cmp) begin
            chk("sink_ready", sink_ready, !m_wr || !mem_waitrequest);
            chk("mem_write", mem_write, m_wr);
            chk("busy", busy, m_in || m_wr);
            chk("frame_done", frame_done,
                m_wr && !mem_waitrequest && m_last);
            chk("frame_count", frame_count, m_fc);
            chk("err_count", err_count, m_ec);
            if (m_wr) begin
                chk("mem_address", mem_address, m_addr);
                chk("mem_writedata", mem_writedata, m_data);
            end
            if (mem_write && !mem_waitrequest) n_wr++;
            if (frame_done) n_done++;
            if (!sink_ready) n_nrdy++;
        end
    end

    bit stall_mode = 0;
    bit rand_mode = 0;
    int stall_left = 0;

    always @(posedge clock) begin
        #2;
        if (stall_mode && mem_write && mem_address == 3'd2
            && stall_left > 0) begin
            mem_waitrequest = 1'b1;
            stall_left--;
        end else if (rand_mode)
            mem_waitrequest = ($urandom_range(0, 3) == 0);
        else
            mem_waitrequest = 1'b0;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] d, input bit sop, input bit eop);
        bit acc;
        int t;
        sink_data = d;
        sink_startofpacket = sop;
        sink_endofpacket = eop;
        sink_valid = 1'b1;
        acc = 0;
        t = 0;
        while (!acc) begin
            @(negedge clock);
            acc = sink_ready;
            @(posedge clock);
            #1;
            t++;
            if (!acc && t > 100) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        sink_valid = 1'b0;
        sink_startofpacket = 1'b0;
        sink_endofpacket = 1'b0;
    endtask

    task automatic do_reset();
        sink_valid = 1'b0;
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        n_wr = 0;
        n_done = 0;
        n_nrdy = 0;
    endtask

    task automatic good_frame(input bit stall);
        stall_mode = stall;
        stall_left = 3;
        for (int i = 0; i < NPIX; i++)
            send(16'h0100 + 16'(i), i == 0, i == NPIX - 1);
        idle(8);
        stall_mode = 0;
    endtask

    initial begin
        idle(3);
        run_cmp = 1;
        reset_n = 1'b1;

        send(16'h0BAD, 0, 0);
        send(16'h0100, 1, 0);
        send(16'h0101, 0, 0);
        do_reset();
        @(negedge clock);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_sink_ready", sink_ready, 1);
        chk("rst_busy", busy, 0);
        idle(1);

        do_reset();
        good_frame(0);
        chk("ff_writes", n_wr, 8);
        chk("ff_done", n_done, 1);
        chk("ff_frame_count", frame_count, 1);
        chk("ff_err_count", err_count, 0);

        do_reset();
        good_frame(1);
        chk("bp_writes", n_wr, 8);
        chk("bp_not_ready", n_nrdy, 3);
        chk("bp_done", n_done, 1);
        chk("bp_frame_count", frame_count, 1);

        do_reset();
        for (int i = 0; i < 5; i++)
            send(16'h0200 + 16'(i), i == 0, i == 4);
        idle(4);
        chk("ee_writes", n_wr, 5);
        chk("ee_err_count", err_count, 1);
        chk("ee_done", n_done, 0);
        chk("ee_frame_count", frame_count, 0);

        do_reset();
        for (int i = 0; i < 3; i++)
            send(16'h0300 + 16'(i), i == 0, 0);
        for (int i = 0; i < NPIX; i++)
            send(16'h0400 + 16'(i), i == 0, i == NPIX - 1);
        idle(4);
        chk("ms_writes", n_wr, 11);
        chk("ms_err_count", err_count, 1);
        chk("ms_done", n_done, 1);
        chk("ms_frame_count", frame_count, 1);

        do_reset();
        for (int i = 0; i < 300; i++)
            send(16'(i), 0, 0);
        idle(2);
        chk("orph_writes", n_wr, 0);
        chk("orph_err_count", err_count, 255);

        do_reset();
        rand_mode = 1;
        for (int f = 0; f < 300; f++) begin
            for (int i = 0; i < NPIX; i++) begin
                bit sop, eop;
                sop = (i == 0) ? ($urandom_range(0, 19) != 0)
                               : ($urandom_range(0, 39) == 0);
                eop = (i == NPIX - 1) ? ($urandom_range(0, 9) != 0)
                                      : ($urandom_range(0, 39) == 0);
                send(16'($urandom), sop, eop);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        rand_mode = 0;
        idle(6);
        chk("rand_some_frames", n_done > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
